// File: rtl/alu_op_sequencer.sv
// Runs 8-bit ADD/SUB/XOR/OR/NOT commands on a shared 4-bit ALU, one nibble per pass.
// SUB first inverts b through the ALU, then adds with carry-in 1.
module alu_op_sequencer (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [2:0] cmd_op,
    input  logic [7:0] cmd_a,
    input  logic [7:0] cmd_b,
    output logic       res_valid,
    input  logic       res_ready,
    output logic [7:0] res_data,
    output logic       res_cout,
    output logic       res_err,
    output logic [3:0] alu_a,
    output logic [3:0] alu_b,
    output logic       alu_cin,
    output logic       alu_s0,
    output logic       alu_s1,
    input  logic [3:0] alu_out,
    input  logic       alu_cout
);

    typedef enum logic [2:0] {IDLE, INV_LO, INV_HI, LO, HI, DONE} state_t;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_XOR = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_NOT = 3'b100;

    localparam logic [1:0] SEL_SUM = 2'b00;
    localparam logic [1:0] SEL_XOR = 2'b01;
    localparam logic [1:0] SEL_OR  = 2'b10;
    localparam logic [1:0] SEL_NOT = 2'b11;

    state_t     state;
    logic [7:0] a_r;
    logic [7:0] b_r;
    logic [7:0] nb_r;
    logic [2:0] op_r;
    logic       carry_r;
    logic [1:0] sel;
    logic       is_sub;
    logic       is_arith;

    function automatic logic [1:0] op_sel(input logic [2:0] op);
        case (op)
            OP_ADD, OP_SUB: op_sel = SEL_SUM;
            OP_XOR:         op_sel = SEL_XOR;
            OP_OR:          op_sel = SEL_OR;
            default:        op_sel = SEL_NOT;
        endcase
    endfunction

    function automatic logic op_legal(input logic [2:0] op);
        op_legal = (op <= OP_NOT);
    endfunction

    assign is_sub   = (op_r == OP_SUB);
    assign is_arith = (op_r == OP_ADD) || (op_r == OP_SUB);

    // ALU drive is a pure decode of the state and the latched operands
    always_comb begin
        alu_a   = 4'h0;
        alu_b   = 4'h0;
        alu_cin = 1'b0;
        sel     = SEL_SUM;
        case (state)
            INV_LO: begin
                alu_a = b_r[3:0];
                sel   = SEL_NOT;
            end
            INV_HI: begin
                alu_a = b_r[7:4];
                sel   = SEL_NOT;
            end
            LO: begin
                alu_a   = a_r[3:0];
                alu_b   = is_sub ? nb_r[3:0] : b_r[3:0];
                alu_cin = is_sub;
                sel     = op_sel(op_r);
            end
            HI: begin
                alu_a   = a_r[7:4];
                alu_b   = is_sub ? nb_r[7:4] : b_r[7:4];
                alu_cin = carry_r;
                sel     = op_sel(op_r);
            end
            default: ;
        endcase
    end

    assign alu_s0    = sel[0];
    assign alu_s1    = sel[1];
    assign cmd_ready = (state == IDLE);
    assign res_valid = (state == DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            a_r      <= 8'h00;
            b_r      <= 8'h00;
            nb_r     <= 8'h00;
            op_r     <= 3'b000;
            carry_r  <= 1'b0;
            res_data <= 8'h00;
            res_cout <= 1'b0;
            res_err  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        a_r      <= cmd_a;
                        b_r      <= cmd_b;
                        op_r     <= cmd_op;
                        res_data <= 8'h00;
                        res_cout <= 1'b0;
                        res_err  <= !op_legal(cmd_op);
                        if (!op_legal(cmd_op))
                            state <= DONE;
                        else if (cmd_op == OP_SUB)
                            state <= INV_LO;
                        else
                            state <= LO;
                    end
                end
                INV_LO: begin
                    nb_r[3:0] <= alu_out;
                    state     <= INV_HI;
                end
                INV_HI: begin
                    nb_r[7:4] <= alu_out;
                    state     <= LO;
                end
                LO: begin
                    res_data[3:0] <= alu_out;
                    carry_r       <= alu_cout;
                    state         <= HI;
                end
                HI: begin
                    res_data[7:4] <= alu_out;
                    res_cout      <= is_arith ? alu_cout : 1'b0;
                    state         <= DONE;
                end
                DONE: begin
                    if (res_ready)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed bench for alu_op_sequencer with a behavioural 4-bit ALU in the loop.
`timescale 1ns/1ps
module tb_alu_op_sequencer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [2:0] cmd_op;
    logic [7:0] cmd_a;
    logic [7:0] cmd_b;
    logic       res_valid;
    logic       res_ready;
    logic [7:0] res_data;
    logic       res_cout;
    logic       res_err;
    logic [3:0] alu_a;
    logic [3:0] alu_b;
    logic       alu_cin;
    logic       alu_s0;
    logic       alu_s1;
    logic [3:0] alu_out;
    logic       alu_cout;
    logic [4:0] alu_sum;

    int total = 0;
    int bad   = 0;

    logic [10:0] snap_lo;
    logic [10:0] snap_hi;

    always #5 clk = ~clk;

    alu_op_sequencer dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_a     (cmd_a),
        .cmd_b     (cmd_b),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_data  (res_data),
        .res_cout  (res_cout),
        .res_err   (res_err),
        .alu_a     (alu_a),
        .alu_b     (alu_b),
        .alu_cin   (alu_cin),
        .alu_s0    (alu_s0),
        .alu_s1    (alu_s1),
        .alu_out   (alu_out),
        .alu_cout  (alu_cout)
    );

    // Combinational 4-bit ALU: {s1,s0} 00 sum, 01 xor, 10 or, 11 not(a)
    assign alu_sum  = {1'b0, alu_a} + {1'b0, alu_b} + {4'b0, alu_cin};
    assign alu_cout = alu_sum[4];
    always_comb begin
        case ({alu_s1, alu_s0})
            2'b00:   alu_out = alu_sum[3:0];
            2'b01:   alu_out = alu_a ^ alu_b;
            2'b10:   alu_out = alu_a | alu_b;
            default: alu_out = ~alu_a;
        endcase
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Issue one command, wait for DONE (bounded), check result; optionally consume it.
    task automatic do_op(input string tag, input logic [2:0] op, input logic [7:0] a,
                         input logic [7:0] b, input int lat, input logic [7:0] ed,
                         input logic ec, input logic ee, input bit consume);
        int n;
        @(negedge clk);
        chk({tag, "_cmd_ready"}, cmd_ready, 1);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_a     = a;
        cmd_b     = b;
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        n = 0;
        @(negedge clk);
        while (!res_valid && n < 20) begin
            snap_lo = snap_hi;
            snap_hi = {alu_a, alu_b, alu_cin, alu_s1, alu_s0};
            chk({tag, "_busy_ready"}, cmd_ready, 0);
            n++;
            @(negedge clk);
        end
        chk({tag, "_latency"}, n, lat);
        chk({tag, "_data"}, res_data, ed);
        chk({tag, "_cout"}, res_cout, ec);
        chk({tag, "_err"}, res_err, ee);
        if (consume) begin
            res_ready = 1'b1;
            @(posedge clk);
            #1 res_ready = 1'b0;
            @(negedge clk);
            chk({tag, "_back_idle"}, {cmd_ready, res_valid}, 2'b10);
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        cmd_valid = 1'b0;
        cmd_op    = 3'b000;
        cmd_a     = 8'h00;
        cmd_b     = 8'h00;
        res_ready = 1'b0;
        snap_lo   = '0;
        snap_hi   = '0;
        #12;
        chk("rst_ready", cmd_ready, 1);
        chk("rst_outs", {res_valid, res_data, res_cout, res_err}, 11'h0);
        chk("rst_alu", {alu_a, alu_b, alu_cin, alu_s1, alu_s0}, 11'h0);
        @(negedge clk);
        rst_n = 1'b1;

        do_op("add", 3'b000, 8'h9D, 8'hD9, 2, 8'h76, 1'b1, 1'b0, 1'b1);
        chk("add_lo_pass", snap_lo, {4'hD, 4'h9, 1'b0, 2'b00});
        chk("add_hi_pass", snap_hi, {4'h9, 4'hD, 1'b1, 2'b00});

        do_op("sub1", 3'b001, 8'h50, 8'h23, 4, 8'h2D, 1'b1, 1'b0, 1'b1);
        do_op("sub2", 3'b001, 8'h23, 8'h50, 4, 8'hD3, 1'b0, 1'b0, 1'b1);
        do_op("sub_b0", 3'b001, 8'h5A, 8'h00, 4, 8'h5A, 1'b1, 1'b0, 1'b1);

        do_op("xor", 3'b010, 8'h9D, 8'hD9, 2, 8'h44, 1'b0, 1'b0, 1'b1);
        chk("xor_sel", {snap_lo[1:0], snap_hi[1:0]}, 4'b0101);
        do_op("or", 3'b011, 8'h9D, 8'hD9, 2, 8'hDD, 1'b0, 1'b0, 1'b1);
        chk("or_sel", {snap_lo[1:0], snap_hi[1:0]}, 4'b1010);

        // res_ready already high when DONE is entered
        res_ready = 1'b1;
        do_op("not", 3'b100, 8'h9D, 8'h00, 2, 8'h62, 1'b0, 1'b0, 1'b1);
        chk("not_sel", {snap_lo[1:0], snap_hi[1:0]}, 4'b1111);

        // Backpressure: result held, stray command ignored
        do_op("bp", 3'b000, 8'h9D, 8'hD9, 2, 8'h76, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            if (i == 2) begin
                cmd_valid = 1'b1;
                cmd_op    = 3'b010;
                cmd_a     = 8'hFF;
                cmd_b     = 8'h0F;
            end
            @(posedge clk);
            #1 cmd_valid = 1'b0;
            @(negedge clk);
            chk("bp_hold", {res_valid, cmd_ready, res_data, res_cout}, {1'b1, 1'b0, 8'h76, 1'b1});
        end
        res_ready = 1'b1;
        @(posedge clk);
        #1 res_ready = 1'b0;
        @(negedge clk);
        chk("bp_release", {cmd_ready, res_valid}, 2'b10);

        do_op("illegal", 3'b110, 8'h12, 8'h34, 0, 8'h00, 1'b0, 1'b1, 1'b1);
        do_op("clr_err", 3'b000, 8'h10, 8'h20, 2, 8'h30, 1'b0, 1'b0, 1'b1);

        // Reset during INV_HI of a SUB
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_op    = 3'b001;
        cmd_a     = 8'h50;
        cmd_b     = 8'h23;
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        @(negedge clk);
        chk("sub_inv_lo", {alu_a, alu_s1, alu_s0}, {4'h3, 2'b11});
        @(negedge clk);
        chk("sub_inv_hi", {alu_a, alu_s1, alu_s0}, {4'h2, 2'b11});
        rst_n = 1'b0;
        #1;
        chk("mid_rst_outs", {res_valid, res_data, res_cout, res_err}, 11'h0);
        chk("mid_rst_alu", {alu_a, alu_b, alu_cin, alu_s1, alu_s0}, 11'h0);
        chk("mid_rst_ready", cmd_ready, 1);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst", {cmd_ready, res_valid}, 2'b10);
        do_op("after_rst", 3'b000, 8'h01, 8'h01, 2, 8'h02, 1'b0, 1'b0, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
